// File: rtl/div_pkg.sv
// Shared types and constants for the iterative restoring divider.
// Magnitude/negation helper lives here so the top and any future users agree.
package div_pkg;

  localparam int DIV_WIDTH  = 32;
  localparam int ITER_CNT_W = 5;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    PREP = 3'd1,
    ITER = 3'd2,
    FIX  = 3'd3,
    DONE = 3'd4
  } div_state_e;

  localparam logic [DIV_WIDTH-1:0] DIV0_QUOTIENT = {DIV_WIDTH{1'b1}};

  // Two's-complement negate when neg is set; |0x80000000| stays 0x80000000 as an unsigned magnitude.
  function automatic logic [DIV_WIDTH-1:0] cond_neg(input logic [DIV_WIDTH-1:0] v,
                                                    input logic neg);
    logic [DIV_WIDTH-1:0] r;
    if (neg) begin
      r = ~v + {{(DIV_WIDTH-1){1'b0}}, 1'b1};
    end else begin
      r = v;
    end
    return r;
  endfunction

endpackage

// File: rtl/div_restore_step.sv
// One restoring-division step: shift the partial remainder left, trial-subtract
// the divisor magnitude from the upper half, keep the difference if it fits.
module div_restore_step
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic [2*WIDTH-1:0] rem_i,
  input  logic [WIDTH-1:0]   div_i,
  output logic [2*WIDTH-1:0] rem_o,
  output logic               qbit_o
);

  logic [2*WIDTH:0] shifted_s;
  logic             ge_s;
  logic [WIDTH-1:0] diff_s;

  // The shifted upper half needs WIDTH+1 bits when the divisor exceeds 2^(WIDTH-1).
  always_comb begin
    shifted_s = {rem_i, 1'b0};
    ge_s      = (shifted_s[2*WIDTH:WIDTH] >= {1'b0, div_i});
    diff_s    = shifted_s[2*WIDTH-1:WIDTH] - div_i;
    if (ge_s) begin
      rem_o  = {diff_s, shifted_s[WIDTH-1:0]};
      qbit_o = 1'b1;
    end else begin
      rem_o  = shifted_s[2*WIDTH-1:0];
      qbit_o = 1'b0;
    end
  end

endmodule

// File: rtl/booth_radix2_divider.sv
// Iterative 32-bit signed/unsigned restoring divider with valid/ready handshakes.
// Optional DIV_FAST_PATH_EN skips iteration when y = 0 or |x| < |y|.
module booth_radix2_divider
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic             div_clk,
  input  logic             resetn,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             div_signed,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder
);

  div_state_e            state_q, state_d;
  logic [WIDTH-1:0]      x_q, x_d;
  logic [WIDTH-1:0]      y_q, y_d;
  logic                  sx_q, sx_d;
  logic                  sy_q, sy_d;
  logic [WIDTH-1:0]      ay_q, ay_d;
  logic [2*WIDTH-1:0]    rem_q, rem_d;
  logic [WIDTH-1:0]      quo_q, quo_d;
  logic [ITER_CNT_W-1:0] cnt_q, cnt_d;
  logic                  in_ready_q, in_ready_d;
  logic                  out_valid_q, out_valid_d;
  logic [WIDTH-1:0]      quotient_q, quotient_d;
  logic [WIDTH-1:0]      remainder_q, remainder_d;

  logic [WIDTH-1:0]      ax_s;
  logic [WIDTH-1:0]      ay_s;
  logic [2*WIDTH-1:0]    step_rem_s;
  logic                  step_q_s;

  div_restore_step #(.WIDTH(WIDTH)) u_step (
    .rem_i  (rem_q),
    .div_i  (ay_q),
    .rem_o  (step_rem_s),
    .qbit_o (step_q_s)
  );

  // Next-state, datapath and registered-output decode.
  always_comb begin
    state_d     = state_q;
    x_d         = x_q;
    y_d         = y_q;
    sx_d        = sx_q;
    sy_d        = sy_q;
    ay_d        = ay_q;
    rem_d       = rem_q;
    quo_d       = quo_q;
    cnt_d       = cnt_q;
    quotient_d  = quotient_q;
    remainder_d = remainder_q;
    ax_s        = cond_neg(x_q, sx_q);
    ay_s        = cond_neg(y_q, sy_q);

    case (state_q)
      IDLE: begin
        if (in_valid && in_ready_q) begin
          state_d = PREP;
          x_d     = x;
          y_d     = y;
          sx_d    = x[WIDTH-1] & div_signed;
          sy_d    = y[WIDTH-1] & div_signed;
        end else begin
          state_d = IDLE;
        end
      end
      PREP: begin
        ay_d  = ay_s;
        rem_d = {{WIDTH{1'b0}}, ax_s};
        quo_d = {WIDTH{1'b0}};
        cnt_d = ITER_CNT_W'(WIDTH - 1);
`ifdef DIV_FAST_PATH_EN
        // Quotient is zero; preload the remainder half so FIX restores x's sign.
        if ((y_q == {WIDTH{1'b0}}) || (ax_s < ay_s)) begin
          state_d = FIX;
          rem_d   = {ax_s, {WIDTH{1'b0}}};
        end else begin
          state_d = ITER;
        end
`else
        state_d = ITER;
`endif
      end
      ITER: begin
        rem_d = step_rem_s;
        quo_d = {quo_q[WIDTH-2:0], step_q_s};
        cnt_d = cnt_q - {{(ITER_CNT_W-1){1'b0}}, 1'b1};
        if (cnt_q == {ITER_CNT_W{1'b0}}) begin
          state_d = FIX;
        end else begin
          state_d = ITER;
        end
      end
      FIX: begin
        if (y_q == {WIDTH{1'b0}}) begin
          quotient_d  = DIV0_QUOTIENT;
          remainder_d = x_q;
        end else begin
          quotient_d  = cond_neg(quo_q, sx_q ^ sy_q);
          remainder_d = cond_neg(rem_q[2*WIDTH-1:WIDTH], sx_q);
        end
        state_d = DONE;
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end else begin
          state_d = DONE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    in_ready_d  = (state_d == IDLE);
    out_valid_d = (state_d == DONE);
  end

  // State and datapath registers with synchronous active-high reset.
  always_ff @(posedge div_clk) begin
    if (resetn) begin
      state_q     <= IDLE;
      x_q         <= {WIDTH{1'b0}};
      y_q         <= {WIDTH{1'b0}};
      sx_q        <= 1'b0;
      sy_q        <= 1'b0;
      ay_q        <= {WIDTH{1'b0}};
      rem_q       <= {(2*WIDTH){1'b0}};
      quo_q       <= {WIDTH{1'b0}};
      cnt_q       <= {ITER_CNT_W{1'b0}};
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      quotient_q  <= {WIDTH{1'b0}};
      remainder_q <= {WIDTH{1'b0}};
    end else begin
      state_q     <= state_d;
      x_q         <= x_d;
      y_q         <= y_d;
      sx_q        <= sx_d;
      sy_q        <= sy_d;
      ay_q        <= ay_d;
      rem_q       <= rem_d;
      quo_q       <= quo_d;
      cnt_q       <= cnt_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      quotient_q  <= quotient_d;
      remainder_q <= remainder_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign quotient  = quotient_q;
  assign remainder = remainder_q;

endmodule

// File: tb/tb_booth_radix2_divider.sv
// Scoreboard bench for booth_radix2_divider: directed vectors, queue-based monitor.
module tb_booth_radix2_divider;

  logic        div_clk = 1'b0;
  logic        resetn;
  logic        in_valid;
  logic        in_ready;
  logic        div_signed;
  logic [31:0] x;
  logic [31:0] y;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] quotient;
  logic [31:0] remainder;

  booth_radix2_divider dut (
    .div_clk    (div_clk),
    .resetn     (resetn),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .div_signed (div_signed),
    .x          (x),
    .y          (y),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .quotient   (quotient),
    .remainder  (remainder)
  );

  always #5 div_clk = ~div_clk;

  typedef struct {
    logic [31:0] q;
    logic [31:0] r;
    int          acc;
    int          lat;
  } sb_t;

  typedef struct {
    logic [31:0] xv;
    logic [31:0] yv;
    logic        sg;
    logic [31:0] q;
    logic [31:0] r;
    logic        fast;
  } vec_t;

  sb_t  sb[$];
  int   total = 0;
  int   bad = 0;
  int   edge_cnt = 0;
  logic prev_v = 1'b0;

  always @(posedge div_clk) edge_cnt <= edge_cnt + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Monitor: latency on rising out_valid, data on each accepted transfer.
  always @(negedge div_clk) begin
    if (out_valid && sb.size() == 0) begin
      chk("unexpected_out_valid", 32'(out_valid), 32'd0);
    end else if (out_valid) begin
      if (!prev_v) chk("latency", 32'(edge_cnt - sb[0].acc), 32'(sb[0].lat));
      if (out_ready) begin
        chk("quotient", quotient, sb[0].q);
        chk("remainder", remainder, sb[0].r);
        void'(sb.pop_front());
      end
    end
    prev_v = out_valid;
  end

  function automatic int exp_lat(input logic fast);
`ifdef DIV_FAST_PATH_EN
    return fast ? 2 : 34;
`else
    return (fast === 1'bx) ? 0 : 34;
`endif
  endfunction

  task automatic issue(input vec_t v, input bit push);
    int n = 0;
    sb_t e;
    while (!in_ready && n < 200) begin
      @(posedge div_clk); #1;
      n++;
    end
    if (!in_ready) chk("in_ready_timeout", 32'(in_ready), 32'd1);
    in_valid   = 1'b1;
    x          = v.xv;
    y          = v.yv;
    div_signed = v.sg;
    if (push) begin
      e.q   = v.q;
      e.r   = v.r;
      e.acc = edge_cnt + 1;
      e.lat = exp_lat(v.fast);
      sb.push_back(e);
    end
    @(posedge div_clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 300) begin
      @(posedge div_clk); #1;
      n++;
    end
    if (sb.size() != 0) begin
      chk("drain_timeout", 32'(sb.size()), 32'd0);
      sb.delete();
    end
  endtask

  vec_t vecs[10];

  initial begin
    vecs[0] = '{32'd100,       32'd7,          1'b0, 32'd14,        32'd2,          1'b0};
    vecs[1] = '{32'hFFFFFF9C,  32'd7,          1'b1, 32'hFFFFFFF2,  32'hFFFFFFFE,   1'b0};
    vecs[2] = '{32'd100,       32'hFFFFFFF9,   1'b1, 32'hFFFFFFF2,  32'd2,          1'b0};
    vecs[3] = '{32'h80000000,  32'hFFFFFFFF,   1'b1, 32'h80000000,  32'd0,          1'b0};
    vecs[4] = '{32'h80000000,  32'hFFFFFFFF,   1'b0, 32'd0,         32'h80000000,   1'b1};
    vecs[5] = '{32'd5,         32'd0,          1'b0, 32'hFFFFFFFF,  32'd5,          1'b1};
    vecs[6] = '{32'd5,         32'd0,          1'b1, 32'hFFFFFFFF,  32'd5,          1'b1};
    vecs[7] = '{32'hFFFFFFFB,  32'd0,          1'b1, 32'hFFFFFFFF,  32'hFFFFFFFB,   1'b1};
    vecs[8] = '{32'hFFFFFFFD,  32'd10,         1'b1, 32'd0,         32'hFFFFFFFD,   1'b1};
    vecs[9] = '{32'h80000000,  32'h80000000,   1'b1, 32'd1,         32'd0,          1'b0};

    resetn = 1'b1; in_valid = 1'b0; div_signed = 1'b0;
    x = 32'd0; y = 32'd0; out_ready = 1'b1;
    repeat (3) @(posedge div_clk);
    #1 resetn = 1'b0;
    @(negedge div_clk);
    chk("reset_in_ready", 32'(in_ready), 32'd1);
    chk("reset_out_valid", 32'(out_valid), 32'd0);
    chk("reset_quotient", quotient, 32'd0);
    chk("reset_remainder", remainder, 32'd0);
    @(posedge div_clk); #1;

    for (int i = 0; i < 10; i++) begin
      issue(vecs[i], 1'b1);
      drain();
      @(posedge div_clk); #1;
    end

    // Backpressure: -7 / -2 = 3 rem -1, held for 10 cycles.
    out_ready = 1'b0;
    issue('{32'hFFFFFFF9, 32'hFFFFFFFE, 1'b1, 32'd3, 32'hFFFFFFFF, 1'b0}, 1'b1);
    begin
      int n = 0;
      while (!out_valid && n < 100) begin
        @(posedge div_clk); #1;
        n++;
      end
      chk("bp_valid_seen", 32'(out_valid), 32'd1);
    end
    for (int k = 0; k < 10; k++) begin
      @(negedge div_clk);
      chk("bp_hold_valid", 32'(out_valid), 32'd1);
      chk("bp_hold_q", quotient, 32'd3);
      chk("bp_hold_r", remainder, 32'hFFFFFFFF);
    end
    @(posedge div_clk); #1;
    out_ready = 1'b1;
    drain();
    @(posedge div_clk); #1;

    // Busy: in_valid pulses while iterating are ignored.
    issue(vecs[0], 1'b1);
    for (int k = 0; k < 20; k++) begin
      in_valid = k[0];
      x = 32'd1; y = 32'd1; div_signed = 1'b0;
      @(negedge div_clk);
      chk("busy_in_ready", 32'(in_ready), 32'd0);
      @(posedge div_clk); #1;
    end
    in_valid = 1'b0;
    drain();
    repeat (40) @(posedge div_clk);
    #1;

    // Reset mid-operation, then a fresh unsigned divide.
    issue(vecs[1], 1'b0);
    repeat (15) @(posedge div_clk);
    #1 resetn = 1'b1;
    @(posedge div_clk); #1;
    resetn = 1'b0;
    @(negedge div_clk);
    chk("midrst_in_ready", 32'(in_ready), 32'd1);
    chk("midrst_out_valid", 32'(out_valid), 32'd0);
    repeat (40) @(posedge div_clk);
    #1;
    issue('{32'hFFFFFFFF, 32'h00000010, 1'b0, 32'h0FFFFFFF, 32'h0000000F, 1'b0}, 1'b1);
    drain();
    repeat (5) @(posedge div_clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
